// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared state type and constants for the FIFO-fed UART transmitter
package fifo_uart_tx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int BYTES_PER_WORD       = 4;
  localparam int BITS_PER_BYTE        = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// rtl/fifo_uart_tx_baud_gen.sv - bit-period counter producing one tick per UART bit
module uart_baud_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int               CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count 0..CLKS_PER_BIT-1; clear wins so every state starts on a fresh bit period.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops 32-bit words from a FIFO and sends them as four 8N1 bytes
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int WIDTH        = 32
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic             empty_i,
  input  logic             rx_ack_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             read_enable_o,
  output logic             uart_tx_o,
  output logic             busy_o,
  output logic             word_done_o,
  output logic             ack_err_o
);

  localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             baud_clear, baud_en, baud_tick;

  assign baud_clear = (state_d != state_q);
  assign baud_en    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_sys_i (clk_sys_i),
    .rst_sys_ni(rst_sys_ni),
    .clear     (baud_clear),
    .enable    (baud_en),
    .tick      (baud_tick)
  );

  // Next-state logic. Bytes go out LSB byte first and each byte LSB bit first, so the
  // whole word is simply the shift register drained from bit 0 upward.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty_i) state_d = FETCH;
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (rx_ack_i) begin
          shift_d = data_i;
          byte_d  = '0;
          bit_d   = '0;
          state_d = START;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (byte_q == LAST_BYTE) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = START;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Line level is derived from the next state so the registered output lines up with it.
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[0];
  end

  // State, datapath and registered line/pulse outputs.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign read_enable_o = (state_q == FETCH);
  assign busy_o        = (state_q != IDLE);
  assign uart_tx_o     = tx_q;
  assign word_done_o   = done_q;
  assign ack_err_o     = err_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench with FIFO model and serial line decoder
module tb_fifo_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 40 * CPB;

  logic        clk_sys_i = 1'b0;
  logic        rst_sys_ni;
  logic        empty_i;
  logic        rx_ack_i;
  logic [31:0] data_i;
  logic        read_enable_o;
  logic        uart_tx_o;
  logic        busy_o;
  logic        word_done_o;
  logic        ack_err_o;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .WIDTH       (32)
  ) dut (
    .clk_sys_i    (clk_sys_i),
    .rst_sys_ni   (rst_sys_ni),
    .empty_i      (empty_i),
    .rx_ack_i     (rx_ack_i),
    .data_i       (data_i),
    .read_enable_o(read_enable_o),
    .uart_tx_o    (uart_tx_o),
    .busy_o       (busy_o),
    .word_done_o  (word_done_o),
    .ack_err_o    (ack_err_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // upstream FIFO model
  logic [31:0] fifo_q[$];
  bit          hold_empty = 1'b0;
  bit          nack_next  = 1'b0;
  bit          pend_nack  = 1'b0;
  logic [31:0] pend_word  = '0;
  int          pop_age    = -1;

  // reference and event counters
  logic [7:0] exp_bytes[$];
  int reads = 0, done_pulses = 0, err_pulses = 0, words_rx = 0;
  bit re_prev = 1'b0, done_prev = 1'b0, err_prev = 1'b0;

  // serial line decoder
  bit         rx_active    = 1'b0;
  int         rx_cnt       = 0;
  logic [9:0] rx_bits      = '0;
  bit         rx_glitch    = 1'b0;
  logic       slot_val     = 1'b1;
  int         byte_in_word = 0;
  int         word_start   = 0;
  int         word_end     = -1;
  int         last_gap     = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    if (read_enable_o === 1'b1) begin
      check("re_protocol", 32'({re_prev, empty_i}), 32'd0);
      reads++;
    end
    re_prev = (read_enable_o === 1'b1);

    if (ack_err_o === 1'b1) begin
      err_pulses++;
      check("ack_err_width", 32'(err_prev), 32'd0);
      check("ack_err_state", 32'({busy_o, uart_tx_o}), 32'b01);
    end
    err_prev = (ack_err_o === 1'b1);

    if (word_done_o === 1'b1) begin
      done_pulses++;
      check("done_width", 32'(done_prev), 32'd0);
      check("word_len", 32'(cyc - word_start), 32'(FRAME_CYC));
      check("done_after_word", 32'(done_pulses), 32'(words_rx));
    end
    done_prev = (word_done_o === 1'b1);

    if (!rx_active && uart_tx_o === 1'b0) begin
      rx_active = 1'b1;
      rx_cnt    = 0;
      rx_glitch = 1'b0;
      if (byte_in_word == 0) begin
        if (word_end >= 0) last_gap = cyc - word_end - 1;
        word_start = cyc;
      end
    end
    if (rx_active) begin
      if (rx_cnt % CPB == 0)          slot_val = uart_tx_o;
      else if (uart_tx_o !== slot_val) rx_glitch = 1'b1;
      if (rx_cnt % CPB == CPB / 2) rx_bits[rx_cnt / CPB] = uart_tx_o;
      if (rx_cnt == 10 * CPB - 1) begin
        rx_active = 1'b0;
        check("frame_shape", 32'({rx_glitch, rx_bits[9], rx_bits[0]}), 32'b010);
        check("byte_expected", 32'(exp_bytes.size() > 0), 32'd1);
        if (exp_bytes.size() > 0) check("byte_data", 32'(rx_bits[8:1]), 32'(exp_bytes.pop_front()));
        byte_in_word = (byte_in_word + 1) % 4;
        if (byte_in_word == 0) begin
          word_end = cyc;
          words_rx++;
        end
      end
      rx_cnt++;
    end

    if (pop_age >= 0) pop_age++;
    if (pop_age == 1) begin
      data_i   = pend_word;
      rx_ack_i = !pend_nack;
      if (!pend_nack) for (int b = 0; b < 4; b++) exp_bytes.push_back(pend_word[8*b +: 8]);
    end else if (pop_age == 2) begin
      data_i   = $urandom;
      rx_ack_i = 1'($urandom_range(0, 1));
      pop_age  = -1;
    end
    if (read_enable_o === 1'b1 && fifo_q.size() > 0) begin
      pend_word = fifo_q.pop_front();
      pend_nack = nack_next;
      nack_next = 1'b0;
      pop_age   = 0;
    end
    empty_i = hold_empty || (fifo_q.size() == 0);
  endtask

  task automatic step();
    @(posedge clk_sys_i);
    #1;
    cyc++;
    observe();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while ((busy_o || rx_active || pop_age >= 0 || (!hold_empty && fifo_q.size() > 0)) && n < budget);
    if (n >= budget) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no summary after 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, d0, e0, n, nw;
    logic [31:0] w;

    rst_sys_ni = 1'b0;
    empty_i    = 1'b1;
    rx_ack_i   = 1'b1;
    data_i     = '0;
    repeat (3) step();
    check("reset_outs", 32'({uart_tx_o, busy_o, read_enable_o, word_done_o, ack_err_o}), 32'b10000);
    rst_sys_ni = 1'b1;
    repeat (4) step();
    check("idle_empty_no_pop", 32'(reads), 32'd0);

    // single known word
    r0 = reads; d0 = done_pulses;
    fifo_q.push_back(32'hA55A0F81);
    empty_i = 1'b0;
    run_until_idle("single", 400);
    check("single_reads", 32'(reads - r0), 32'd1);
    check("single_done", 32'(done_pulses - d0), 32'd1);
    check("single_left", 32'(exp_bytes.size()), 32'd0);
    repeat ($urandom_range(1, 5)) step();

    // back-to-back extremes
    r0 = reads; d0 = done_pulses; last_gap = -1;
    fifo_q.push_back(32'h00000000);
    fifo_q.push_back(32'hFFFFFFFF);
    empty_i = 1'b0;
    run_until_idle("b2b", 800);
    check("b2b_reads", 32'(reads - r0), 32'd2);
    check("b2b_done", 32'(done_pulses - d0), 32'd2);
    check("b2b_gap", 32'(last_gap), 32'd3);
    check("b2b_left", 32'(exp_bytes.size()), 32'd0);
    repeat ($urandom_range(1, 5)) step();

    // random back-to-back burst
    r0 = reads; d0 = done_pulses; last_gap = -1;
    nw = $urandom_range(2, 4);
    for (int i = 0; i < nw; i++) fifo_q.push_back($urandom);
    empty_i = 1'b0;
    run_until_idle("burst", 900);
    check("burst_reads", 32'(reads - r0), 32'(nw));
    check("burst_done", 32'(done_pulses - d0), 32'(nw));
    check("burst_gap", 32'(last_gap), 32'd3);
    check("burst_left", 32'(exp_bytes.size()), 32'd0);
    repeat ($urandom_range(1, 5)) step();

    // empty_i rises during byte 1 data bits
    r0 = reads; d0 = done_pulses;
    w = $urandom;
    fifo_q.push_back(w);
    fifo_q.push_back(~w);
    empty_i = 1'b0;
    n = 0;
    while (!(rx_active && byte_in_word == 1 && rx_cnt >= 2 * CPB) && n < 300) begin
      step();
      n++;
    end
    check("toggle_reach_byte1", 32'(n < 300), 32'd1);
    hold_empty = 1'b1;
    empty_i    = 1'b1;
    run_until_idle("toggle_first", 400);
    check("toggle_one_pop", 32'(reads - r0), 32'd1);
    check("toggle_done", 32'(done_pulses - d0), 32'd1);
    repeat (20) step();
    check("toggle_no_pop_empty", 32'(reads - r0), 32'd1);
    hold_empty = 1'b0;
    empty_i    = 1'b0;
    run_until_idle("toggle_second", 400);
    check("toggle_reads", 32'(reads - r0), 32'd2);
    check("toggle_done2", 32'(done_pulses - d0), 32'd2);
    check("toggle_left", 32'(exp_bytes.size()), 32'd0);
    repeat ($urandom_range(1, 5)) step();

    // nack on capture, then a normal word
    r0 = reads; d0 = done_pulses; e0 = err_pulses;
    nack_next = 1'b1;
    fifo_q.push_back($urandom);
    fifo_q.push_back($urandom);
    empty_i = 1'b0;
    run_until_idle("nack", 600);
    check("nack_err", 32'(err_pulses - e0), 32'd1);
    check("nack_reads", 32'(reads - r0), 32'd2);
    check("nack_done", 32'(done_pulses - d0), 32'd1);
    check("nack_left", 32'(exp_bytes.size()), 32'd0);
    repeat ($urandom_range(1, 5)) step();

    // reset in the middle of byte 2
    fifo_q.push_back($urandom);
    empty_i = 1'b0;
    n = 0;
    while (!(rx_active && byte_in_word == 2 && rx_cnt >= 3 * CPB) && n < 300) begin
      step();
      n++;
    end
    check("rst_reach_byte2", 32'(n < 300), 32'd1);
    rst_sys_ni   = 1'b0;
    rx_active    = 1'b0;
    byte_in_word = 0;
    word_end     = -1;
    exp_bytes.delete();
    repeat (3) step();
    check("rst_hold_outs", 32'({uart_tx_o, busy_o, read_enable_o, word_done_o}), 32'b1000);
    rst_sys_ni = 1'b1;
    step();
    check("rst_release_outs", 32'({uart_tx_o, busy_o, read_enable_o}), 32'b100);
    r0 = reads; d0 = done_pulses;
    repeat (10) step();
    check("rst_no_pop", 32'(reads - r0), 32'd0);
    fifo_q.push_back($urandom);
    empty_i = 1'b0;
    run_until_idle("rst_recover", 400);
    check("rst_recover_reads", 32'(reads - r0), 32'd1);
    check("rst_recover_done", 32'(done_pulses - d0), 32'd1);
    check("rst_recover_left", 32'(exp_bytes.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
